// File: rtl/ahb_rr_bus_arbiter.sv
// ============================================================================
// Module   : ahb_rr_bus_arbiter
// Brief    : Round-robin AHB-Lite arbiter for the shared external memory port.
//            The optional grant-hold timeout is enabled by defining ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_rr_bus_arbiter #(
   parameter int N_MASTERS      = 3,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic [2*N_MASTERS-1:0]       i_HTRANS,
   input  logic [N_MASTERS-1:0]         i_slave_done,
   output logic [N_MASTERS-1:0]         o_HREADY,
   output logic [$clog2(N_MASTERS)-1:0] o_grant_id,
   output logic                         o_bus_busy,
   output logic                         o_timeout
);

   localparam int GID_W = $clog2(N_MASTERS);

   if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("ahb_rr_bus_arbiter: N_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
   end

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t               state_q;
   logic [N_MASTERS-1:0] hready_q;
   logic [GID_W-1:0]     grant_id_q;
   logic [GID_W-1:0]     last_grant_q;
   logic                 busy_q;

   logic [N_MASTERS-1:0] req;
   logic [GID_W-1:0]     win_id;
   logic                 win_vld;
   logic                 done_g;

   // NONSEQ and SEQ are the only HTRANS codes that carry a transfer
   always_comb begin
      req = '0;
      for (int m = 0; m < N_MASTERS; m++) begin
         req[m] = (i_HTRANS[2*m +: 2] == 2'b10) || (i_HTRANS[2*m +: 2] == 2'b11);
      end
   end

   always_comb begin
      int idx;
      idx     = 0;
      win_vld = 1'b0;
      win_id  = '0;
      for (int k = 1; k <= N_MASTERS; k++) begin
         idx = (int'(last_grant_q) + k) % N_MASTERS;
         if (!win_vld && req[idx]) begin
            win_vld = 1'b1;
            win_id  = GID_W'(idx);
         end
      end
   end

   // hready_q is onehot(grant_id_q) in GRANT, so this picks the owner's done
   assign done_g = |(i_slave_done & hready_q);

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] hold_q;
   logic             timeout_q;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= S_IDLE;
         hready_q     <= '0;
         grant_id_q   <= '0;
         last_grant_q <= GID_W'(N_MASTERS - 1);
         busy_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_q       <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            S_IDLE: begin
               if (win_vld) begin
                  state_q      <= S_GRANT;
                  grant_id_q   <= win_id;
                  last_grant_q <= win_id;
                  hready_q     <= {{(N_MASTERS-1){1'b0}}, 1'b1} << win_id;
                  busy_q       <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  hold_q       <= '0;
`endif
               end
            end
            S_GRANT: begin
               if (done_g) begin
                  state_q  <= S_IDLE;
                  hready_q <= '0;
                  busy_q   <= 1'b0;
               end
`ifdef ARB_TIMEOUT_EN
               // last_grant_q keeps the offender so it drops to lowest priority
               else if (hold_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state_q   <= S_IDLE;
                  hready_q  <= '0;
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
`endif
            end
            default: begin
               state_q  <= S_IDLE;
               hready_q <= '0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign o_HREADY   = hready_q;
   assign o_grant_id = grant_id_q;
   assign o_bus_busy = busy_q;
`ifdef ARB_TIMEOUT_EN
   assign o_timeout  = timeout_q;
`else
   assign o_timeout  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb_rr_bus_arbiter.sv
// ============================================================================
// Module   : tb_ahb_rr_bus_arbiter
// Brief    : Directed self-checking bench for ahb_rr_bus_arbiter (3 masters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_rr_bus_arbiter;

   logic       HCLK = 1'b0;
   logic       HRESETn;
   logic [5:0] htrans;
   logic [2:0] done;
   logic [2:0] hready;
   logic [1:0] gid;
   logic       busy;
   logic       tmo;

   int n_cmp = 0;
   int n_err = 0;

   ahb_rr_bus_arbiter #(
      .N_MASTERS      (3),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .i_HTRANS     (htrans),
      .i_slave_done (done),
      .o_HREADY     (hready),
      .o_grant_id   (gid),
      .o_bus_busy   (busy),
      .o_timeout    (tmo)
   );

   always #5 HCLK = ~HCLK;

   // One-hot invariant sampled on every falling edge
   always @(negedge HCLK) begin
      if (HRESETn === 1'b1) begin
         n_cmp++;
         if ($countones(hready) > 1) begin
            n_err++;
            $display("FAIL onehot_invariant: HREADY=%b, required at most one bit set", hready);
         end
      end
   end

   task automatic do_reset();
      HRESETn = 1'b0;
      htrans  = '0;
      done    = '0;
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      htrans  = '0;
      done    = '0;
      @(negedge HCLK);
      n_cmp++;
      if (hready !== 3'b000) begin n_err++; $display("FAIL reset_hready: got %b want 000", hready); end
      n_cmp++;
      if (gid !== 2'd0) begin n_err++; $display("FAIL reset_grant_id: got %0d want 0", gid); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++;
      if (tmo !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", tmo); end
      @(negedge HCLK);
      HRESETn = 1'b1;
   endtask

   task automatic test_single_grant();
      do_reset();
      htrans = 6'b00_00_10;
      @(negedge HCLK);
      n_cmp++;
      if (hready !== 3'b001) begin n_err++; $display("FAIL single_hready: got %b want 001", hready); end
      n_cmp++;
      if (gid !== 2'd0) begin n_err++; $display("FAIL single_grant_id: got %0d want 0", gid); end
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
      done   = 3'b001;
      htrans = '0;
      @(negedge HCLK);
      done = '0;
      n_cmp++;
      if (hready !== 3'b000) begin n_err++; $display("FAIL single_release: got %b want 000", hready); end
      n_cmp++;
      if (busy !== 1'b0 || gid !== 2'd0) begin
         n_err++; $display("FAIL single_idle_state: busy=%b gid=%0d want busy=0 gid=0", busy, gid);
      end
   endtask

   task automatic test_rotation();
      logic [2:0] exp_oh;
      do_reset();
      htrans = 6'b10_10_10;
      @(negedge HCLK);
      for (int i = 0; i < 6; i++) begin
         exp_oh = 3'b001 << (i % 3);
         n_cmp++;
         if (hready !== exp_oh || gid !== 2'(i % 3)) begin
            n_err++; $display("FAIL rotation_grant%0d: hready=%b gid=%0d want %b/%0d", i, hready, gid, exp_oh, i % 3);
         end
         repeat (3) @(negedge HCLK);
         n_cmp++;
         if (hready !== exp_oh) begin
            n_err++; $display("FAIL rotation_hold%0d: hready=%b want %b", i, hready, exp_oh);
         end
         done = exp_oh;
         @(negedge HCLK);
         done = '0;
         n_cmp++;
         if (hready !== 3'b000 || busy !== 1'b0) begin
            n_err++; $display("FAIL rotation_dead_cycle%0d: hready=%b busy=%b want 000/0", i, hready, busy);
         end
         @(negedge HCLK);
      end
      htrans = '0;
   endtask

   task automatic test_no_preempt();
      do_reset();
      htrans = 6'b00_10_00;
      @(negedge HCLK);
      n_cmp++;
      if (hready !== 3'b010) begin n_err++; $display("FAIL nopre_grant: got %b want 010", hready); end
      done   = 3'b100;
      htrans = 6'b00_10_10;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         done = '0;
         n_cmp++;
         if (hready !== 3'b010 || gid !== 2'd1) begin
            n_err++; $display("FAIL nopre_hold%0d: hready=%b gid=%0d want 010/1", i, hready, gid);
         end
      end
      done = 3'b010;
      @(negedge HCLK);
      done = '0;
      n_cmp++;
      if (hready !== 3'b000) begin n_err++; $display("FAIL nopre_release: got %b want 000", hready); end
      @(negedge HCLK);
      n_cmp++;
      if (hready !== 3'b001 || gid !== 2'd0) begin
         n_err++; $display("FAIL nopre_next: hready=%b gid=%0d want 001/0", hready, gid);
      end
      htrans = '0;
      done   = 3'b001;
      @(negedge HCLK);
      done = '0;
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      htrans = 6'b00_00_10;
      @(negedge HCLK);
      n_cmp++;
      if (hready !== 3'b001) begin n_err++; $display("FAIL midrst_grant: got %b want 001", hready); end
      htrans = 6'b10_00_10;
      @(negedge HCLK);
      #2;
      HRESETn = 1'b0;
      #1;
      n_cmp++;
      if (hready !== 3'b000 || busy !== 1'b0) begin
         n_err++; $display("FAIL midrst_async: hready=%b busy=%b want 000/0", hready, busy);
      end
      @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      n_cmp++;
      if (hready !== 3'b001 || gid !== 2'd0) begin
         n_err++; $display("FAIL midrst_pointer: hready=%b gid=%0d want 001/0", hready, gid);
      end
      htrans = '0;
      done   = 3'b001;
      @(negedge HCLK);
      done = '0;
   endtask

   task automatic test_busy_no_request();
      do_reset();
      htrans = 6'b01_01_01;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         n_cmp++;
         if (hready !== 3'b000 || busy !== 1'b0) begin
            n_err++; $display("FAIL busy_htrans%0d: hready=%b busy=%b want 000/0", i, hready, busy);
         end
      end
      htrans = '0;
   endtask

   task automatic test_timeout();
      do_reset();
      htrans = 6'b00_00_10;
      @(negedge HCLK);
      n_cmp++;
      if (hready !== 3'b001) begin n_err++; $display("FAIL hold_grant: got %b want 001", hready); end
      htrans = 6'b00_10_00;
`ifdef ARB_TIMEOUT_EN
      for (int i = 1; i < 8; i++) begin
         @(negedge HCLK);
         n_cmp++;
         if (hready !== 3'b001 || tmo !== 1'b0) begin
            n_err++; $display("FAIL tmo_hold%0d: hready=%b tmo=%b want 001/0", i, hready, tmo);
         end
      end
      @(negedge HCLK);
      n_cmp++;
      if (hready !== 3'b000 || tmo !== 1'b1) begin
         n_err++; $display("FAIL tmo_fire: hready=%b tmo=%b want 000/1", hready, tmo);
      end
      @(negedge HCLK);
      n_cmp++;
      if (hready !== 3'b010 || tmo !== 1'b0) begin
         n_err++; $display("FAIL tmo_next: hready=%b tmo=%b want 010/0", hready, tmo);
      end
      htrans = '0;
      done   = 3'b010;
      @(negedge HCLK);
      done = '0;
`else
      for (int i = 0; i < 20; i++) begin
         @(negedge HCLK);
         n_cmp++;
         if (hready !== 3'b001 || tmo !== 1'b0) begin
            n_err++; $display("FAIL hold_forever%0d: hready=%b tmo=%b want 001/0", i, hready, tmo);
         end
      end
      htrans = '0;
      done   = 3'b001;
      @(negedge HCLK);
      done = '0;
      n_cmp++;
      if (hready !== 3'b000) begin n_err++; $display("FAIL hold_release: got %b want 000", hready); end
`endif
   endtask

   initial begin
      HRESETn = 1'b0;
      htrans  = '0;
      done    = '0;
      test_reset();
      test_single_grant();
      test_rotation();
      test_no_preempt();
      test_reset_mid_grant();
      test_busy_no_request();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ahb_rr_bus_arbiter.md
Name: ahb_rr_bus_arbiter

Overview:
- Round-robin arbiter granting a single shared AHB-Lite slave path (external memory port) to up to N masters: ReadSystem, CPU write system, background traffic master.
- Samples each master's HTRANS as its request and returns a one-hot HREADY as the grant.
- Holds each grant until the granted master's slave_done pulse.
- Sits between the master tops and the memory interface, replacing the fixed switch.

Parameters:
- N_MASTERS, 3, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 64, maximum grant hold in cycles; used only when ARB_TIMEOUT_EN is defined.

Ports:
- HCLK  input  1  bus clock, all logic on rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- i_HTRANS  input  2*N_MASTERS  packed HTRANS per master; master m at [2m+1:2m]; IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- i_slave_done  input  N_MASTERS  per-master single-cycle transfer-complete pulse.
- o_HREADY  output  N_MASTERS  one-hot grant; at most one bit set.
- o_grant_id  output  $clog2(N_MASTERS)  index of the current or last granted master.
- o_bus_busy  output  1  high while in GRANT.
- o_timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync deassert by HCLK edge):
  - state=IDLE, o_HREADY=0, o_grant_id=0, o_bus_busy=0, o_timeout=0.
  - last_grant=N_MASTERS-1, so master 0 wins the first tie.
- Request: req[m] = (i_HTRANS[m] == NONSEQ) or (i_HTRANS[m] == SEQ). BUSY and IDLE are not requests.
- Winner selection: the first set req[m] scanning m = last_grant+1, last_grant+2, ... modulo N_MASTERS. Purely combinational from registered last_grant.
- State IDLE:
  - If any req is set at edge k: state goes to GRANT, grant_id and last_grant take the winner, o_HREADY is set one-hot and o_bus_busy=1, all registered at edge k.
  - Grant latency: 1 cycle from request visible to HREADY high.
  - No request: remain in IDLE, outputs 0.
- State GRANT:
  - o_HREADY = onehot(grant_id), held stable.
  - Requests from other masters are ignored; there is no preemption.
  - i_slave_done[grant_id] sampled at edge k: state goes to IDLE, o_HREADY=0, o_bus_busy=0 at edge k.
  - Minimum one dead cycle between successive grants; the next arbitration is at edge k+1.
  - slave_done from non-granted masters is ignored; no state change, no error.
  - If the granted master drops to IDLE HTRANS without done: remain in GRANT (with the macro enabled, timeout applies).
- Simultaneous events:
  - Done and a new request on the same edge: release first; the request is served at the next edge.
  - All N masters requesting continuously: grants rotate 0,1,2,0,... Each master waits at most N_MASTERS-1 grants.
- o_grant_id retains the last winner in IDLE.
- Reset mid-GRANT: o_HREADY drops immediately (asynchronous) and the rotation pointer returns to its reset value.
- Invariant: $countones(o_HREADY) <= 1 at all times.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - hold_cnt clears on entering GRANT and increments each GRANT cycle (saturating width $clog2(TIMEOUT_CYCLES+1)).
  - If hold_cnt reaches TIMEOUT_CYCLES without done: forced return to IDLE, o_HREADY=0, o_timeout=1 for exactly one cycle.
  - last_grant keeps the offender, so it gets lowest priority next round.
  - Done on the same edge as timeout: treated as a normal release, o_timeout stays 0.
- When undefined: no counter logic, o_timeout tied 0, and a grant may be held indefinitely.

Test Plan:
- Reset, then i_HTRANS[1:0]=NONSEQ only -> o_HREADY=3'b001 one cycle later, o_grant_id=0, o_bus_busy=1. Pulse i_slave_done[0] -> o_HREADY=0 next edge.
- All three masters NONSEQ continuously, each done 4 cycles after grant -> grant order 0,1,2,0,1,2. One IDLE cycle between grants. o_HREADY never multi-hot.
- Master 1 granted; pulse i_slave_done[2] and change i_HTRANS of master 0 -> no change, o_HREADY stays 3'b010 until i_slave_done[1].
- Master 2 requests only while master 0 holds; assert HRESETn=0 mid-grant -> o_HREADY=0 immediately. After release with master 2 and master 0 both requesting -> master 0 wins (pointer reset).
- BUSY (01) on all masters -> no grant, state stays IDLE, o_bus_busy=0.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, master 0 never sends done while master 1 requests -> o_timeout pulses 8 GRANT cycles after the grant, next grant goes to master 1. Without the macro -> master 0 holds indefinitely, o_timeout=0.
